// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one async-FIFO write port among
//               NUM_REQ write-domain clients. Grants bursts of up to
//               MAX_BURST beats and throttles on FIFO full / almost-full.
//               Optional macro FIFO_WR_ARB_PRIO_EN gives client 0 fixed
//               priority over the round-robin clients.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          w_full,
  input  logic                          w_afull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         d_out,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                  state_q,  state_d;
  logic [IDX_W-1:0]        owner_q,  owner_d;
  logic [NUM_REQ-1:0]      gnt_q,    gnt_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    w_en_q,   w_en_d;
  logic [DATA_WIDTH-1:0]   d_out_q,  d_out_d;

  logic                    win_valid;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W:0]          scan_sum;
  logic [IDX_W-1:0]        scan_idx;
  logic                    beat;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic [IDX_W-1:0]        ptr_after_owner;

  // Data slice of the current owner and the pointer just past it (with wrap).
  assign owner_data      = data_in[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  // Winner search: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[IDX_W-1:0];
`ifdef FIFO_WR_ARB_PRIO_EN
      // Client 0 is handled separately below; the rotation covers the others.
      if (!win_valid && req[scan_idx] && (scan_idx != '0)) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
`else
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
`endif
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    // Client 0 overrides whatever the rotation picked.
    if (req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Beat acceptance: owner requesting and the FIFO can take one more word.
  // With almost-full, a write already landing this cycle consumes the last slot.
  always_comb begin
    ack  = '0;
    beat = (state_q == ST_GRANT) && req[owner_q] && !w_full && !(w_afull && w_en_q);
    if (beat) begin
      ack[owner_q] = 1'b1;
    end
  end

  // Next-state logic for arbitration, burst counting and write-port outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    w_en_d   = 1'b0;
    d_out_d  = d_out_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          owner_d = win_idx;
          gnt_d   = NUM_REQ'(1) << win_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          w_en_d  = 1'b1;
          d_out_d = owner_data;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if (!req[owner_q] || (beat && (cnt_q == LAST_BEAT))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
`ifdef FIFO_WR_ARB_PRIO_EN
          // The priority client does not disturb the rotation of the others.
          if (owner_q != '0) begin
            rr_ptr_d = ptr_after_owner;
          end
`else
          rr_ptr_d = ptr_after_owner;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops any in-flight beat.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      w_en_q   <= 1'b0;
      d_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= w_en_d;
      d_out_q  <= d_out_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = (state_q == ST_GRANT);
  assign w_en  = w_en_q;
  assign d_out = d_out_q;

endmodule
`default_nettype wire
